// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side handshake and the uart-side strobes of the
//   UART transmit arbiter.
//   master : arbiter view (drives req_ready, tx_data, tx_wr, grant_id,
//            locked, timeout_err; observes requests and uart status)
//   slave  : environment view (requesters + uart), the mirror image
//   Signals:
//     req_valid[N]   requester i has a byte pending
//     req_data[8N]   byte of requester i at [8i+7:8i]
//     req_last[N]    byte of requester i ends its packet
//     req_ready[N]   one-hot accept strobe (byte consumed on valid & ready)
//     tx_data[8]     byte to the uart
//     tx_wr          one-cycle write strobe to the uart
//     tx_busy        uart transmitter busy
//     tx_done        uart end-of-stop-bit pulse
//     grant_id[3]    current or last granted requester
//     locked         packet in progress
//     timeout_err    one-cycle watchdog abort pulse
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_busy;
  logic           tx_done;
  logic [2:0]     grant_id;
  logic           locked;
  logic           timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_data, tx_wr, grant_id, locked, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_data, tx_wr, grant_id, locked, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one 8N1 uart transmitter among N byte
//   streams. A grant is held for a whole packet (through the byte flagged
//   last), exactly one byte is issued per uart frame, and a watchdog aborts
//   a frame whose tx_done never arrives.
//   Ports:
//     clk    system clock
//     reset  synchronous active-high reset (also resets the uart)
//     bus    uart_tx_arbiter_if.master, see the interface for signal list
//   Parameters:
//     N            number of requesters, 2..8
//     TIMEOUT_CYC  cycles allowed from tx_wr to tx_done before abort
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic            locked_q, locked_d;
  logic            last_q, last_d;
  logic [7:0]      data_q, data_d;
  logic [WD_W-1:0] wd_q, wd_d;

  int              best_dist_s;
  int              dist_s;
  logic            take_s;
  logic            found_s;
  logic [2:0]      win_s;
  logic [7:0]      win_data_s;
  logic            win_last_s;
  logic            accept_s;

  // Index following g, wrapping at N.
  function automatic logic [2:0] next_idx(input logic [2:0] g);
    return (g == 3'(N - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  // Round-robin winner: smallest distance from rr_ptr among valid candidates;
  // while a packet is locked only the granted requester is a candidate.
  always_comb begin
    best_dist_s = N;
    dist_s      = 0;
    take_s      = 1'b0;
    win_s       = 3'd0;
    win_data_s  = 8'h00;
    win_last_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      dist_s      = (i + N - int'(rr_ptr_q)) % N;
      take_s      = bus.req_valid[i] && (!locked_q || (grant_q == 3'(i))) &&
                    (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      win_s       = take_s ? 3'(i) : win_s;
      win_data_s  = take_s ? bus.req_data[8*i +: 8] : win_data_s;
      win_last_s  = take_s ? bus.req_last[i] : win_last_s;
    end
    found_s  = (best_dist_s < N);
    // Gated by reset so no byte is handed over in a cycle the arbiter ignores.
    accept_s = (state_q == S_IDLE) && !bus.tx_busy && found_s && !reset;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept_s ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done || (wd_q == {WD_W{1'b0}})) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: byte latch, grant/lock bookkeeping, watchdog.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    last_d   = last_q;
    data_d   = data_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          data_d   = win_data_s;
          last_d   = win_last_s;
          grant_d  = win_s;
          locked_d = ~win_last_s;
        end else begin
          data_d   = data_q;
        end
      end
      S_ISSUE: wd_d = WD_LOAD;
      S_WAIT: begin
        wd_d = (wd_q != {WD_W{1'b0}}) ? wd_q - WD_W'(1) : wd_q;
        // tx_done has priority over a coinciding watchdog expiry.
        if (bus.tx_done) begin
          rr_ptr_d = last_q ? next_idx(grant_q) : rr_ptr_q;
        end else if (wd_q == {WD_W{1'b0}}) begin
          locked_d = 1'b0;
          rr_ptr_d = next_idx(grant_q);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      default: wd_d = {WD_W{1'b0}};
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 3'd0;
      grant_q  <= 3'd0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= 8'h00;
      wd_q     <= {WD_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      data_q   <= data_d;
      wd_q     <= wd_d;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.req_ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      bus.req_ready[i] = accept_s && (win_s == 3'(i));
    end
    bus.tx_wr       = (state_q == S_ISSUE);
    bus.timeout_err = (state_q == S_WAIT) && (wd_q == {WD_W{1'b0}}) && !bus.tx_done;
    bus.tx_data     = data_q;
    bus.grant_id    = grant_q;
    bus.locked      = locked_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter: requester byte queues and a small
//   uart model (busy for a short frame plus one cycle after tx_done) drive
//   the DUT; expected bytes with their grant/lock state are queued when
//   stimulus is created and compared on every tx_wr.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int FRAME = 6;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] gid;
    logic       lck;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();
  uart_tx_arbiter #(.N(N), .TIMEOUT_CYC(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [8:0] src_mem [N][64];
  int   src_wr [N];
  int   src_rd [N];
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   last_wr_cyc = 0;
  int   last_done_cyc = 0;
  bit   have_done = 1'b0;
  bit   gap_chk = 1'b0;
  bit   mute = 1'b0;
  bit   to_allowed = 1'b0;
  bit   to_seen = 1'b0;
  bit   to_chk_next = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic src_push(input int r, input logic [7:0] d, input logic last);
    src_mem[r][src_wr[r]] = {last, d};
    src_wr[r]++;
  endtask

  task automatic exp_push(input logic [7:0] d, input logic [2:0] g, input logic l);
    exp_t e;
    e.data = d; e.gid = g; e.lck = l;
    exp_q.push_back(e);
  endtask

  // Reset the DUT and uart model, empty requester queues and scoreboard.
  task automatic start_test(input bit gap);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) src_wr[i] = src_rd[i];
    exp_q.delete();
    gap_chk = gap;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (12) @(posedge clk);
    #2;
  endtask

  // Engine: output monitor after each rising edge, uart model and requester
  // drive on each falling edge.
  initial begin : engine
    logic       u_busy, u_done, u_post;
    int         u_cnt;
    logic [N-1:0] pend;
    exp_t       e;
    u_busy = 1'b0; u_done = 1'b0; u_post = 1'b0; u_cnt = 0; pend = '0;
    for (int i = 0; i < N; i++) src_rd[i] = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    forever begin
      @(posedge clk); cyc++; #1;
      if (bus.tx_done) begin
        last_done_cyc = cyc;
        have_done = 1'b1;
      end
      if (bus.tx_wr) begin
        check_eq("busy_at_wr", bus.tx_busy, 0);
        check_eq("wr_latency", cyc, last_acc_cyc + 1);
        if (gap_chk && have_done) check_eq("done_to_wr", cyc - last_done_cyc, 2);
        last_wr_cyc = cyc;
        check_eq("sb_avail", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("tx_data", bus.tx_data, e.data);
          check_eq("grant_id", bus.grant_id, e.gid);
          check_eq("locked", bus.locked, e.lck);
        end
      end
      if (to_chk_next) begin
        check_eq("to_pulse_len", bus.timeout_err, 0);
        check_eq("to_locked", bus.locked, 0);
        to_chk_next = 1'b0;
      end
      if (!to_allowed) begin
        check_eq("no_timeout", bus.timeout_err, 0);
      end else if (bus.timeout_err) begin
        check_eq("to_latency", cyc - last_wr_cyc, TO);
        to_seen = 1'b1;
        to_chk_next = 1'b1;
      end

      @(negedge clk);
      if (reset) begin
        u_busy = 1'b0; u_done = 1'b0; u_post = 1'b0; u_cnt = 0;
        have_done = 1'b0;
      end else if (bus.tx_wr) begin
        u_busy = 1'b1; u_cnt = FRAME; u_done = 1'b0;
      end else if (u_done) begin
        u_done = 1'b0; u_post = 1'b1;
      end else if (u_post) begin
        u_post = 1'b0; u_busy = 1'b0;
      end else if (u_busy && u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          if (mute) u_busy = 1'b0;
          else      u_done = 1'b1;
        end
      end
      bus.tx_busy = u_busy;
      bus.tx_done = u_done;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
        bus.req_valid[i]      = (src_rd[i] < src_wr[i]);
        bus.req_data[8*i +: 8] = bus.req_valid[i] ? src_mem[i][src_rd[i]][7:0] : 8'h00;
        bus.req_last[i]       = bus.req_valid[i] ? src_mem[i][src_rd[i]][8] : 1'b0;
      end
      #1;
      pend = bus.req_ready & bus.req_valid;
      if (bus.req_ready != '0) begin
        check_eq("ready_onehot", $countones(bus.req_ready), 1);
        check_eq("ready_valid", bus.req_ready & ~bus.req_valid, 0);
        last_acc_cyc = cyc;
      end
    end
  end

  initial begin : guard
    #300000;
    $display("FAIL global_timeout: bench did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "bench stuck");
  end

  initial begin : main
    int n;
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_wr[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_tx_wr", bus.tx_wr, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_grant_id", bus.grant_id, 0);
    check_eq("rst_locked", bus.locked, 0);
    check_eq("rst_timeout", bus.timeout_err, 0);

    // Single byte, then a pair showing rr_ptr moved past requester 0.
    start_test(1'b0);
    src_push(0, 8'h55, 1'b1);
    exp_push(8'h55, 3'd0, 1'b0);
    wait_drain(200);
    check_eq("single_grant", bus.grant_id, 0);
    check_eq("single_locked", bus.locked, 0);
    src_push(0, 8'h56, 1'b1);
    src_push(1, 8'h57, 1'b1);
    exp_push(8'h57, 3'd1, 1'b0);
    exp_push(8'h56, 3'd0, 1'b0);
    wait_drain(200);

    // Round robin over all four with back-to-back spacing checks.
    start_test(1'b1);
    src_push(0, 8'hA0, 1'b1); src_push(0, 8'hB0, 1'b1);
    src_push(1, 8'hA1, 1'b1);
    src_push(2, 8'hA2, 1'b1);
    src_push(3, 8'hA3, 1'b1);
    exp_push(8'hA0, 3'd0, 1'b0);
    exp_push(8'hA1, 3'd1, 1'b0);
    exp_push(8'hA2, 3'd2, 1'b0);
    exp_push(8'hA3, 3'd3, 1'b0);
    exp_push(8'hB0, 3'd0, 1'b0);
    wait_drain(400);

    // Packet lock: requester 2's 3-byte packet is not interleaved.
    start_test(1'b1);
    src_push(1, 8'h20, 1'b1); src_push(1, 8'h21, 1'b1);
    src_push(2, 8'h10, 1'b0); src_push(2, 8'h11, 1'b0); src_push(2, 8'h12, 1'b1);
    exp_push(8'h20, 3'd1, 1'b0);
    exp_push(8'h10, 3'd2, 1'b1);
    exp_push(8'h11, 3'd2, 1'b1);
    exp_push(8'h12, 3'd2, 1'b0);
    exp_push(8'h21, 3'd1, 1'b0);
    wait_drain(400);

    // Watchdog: silent uart aborts requester 1's packet, requester 2 is next.
    start_test(1'b0);
    mute = 1'b1;
    to_allowed = 1'b1;
    to_seen = 1'b0;
    src_push(1, 8'h40, 1'b0); src_push(1, 8'h41, 1'b1);
    src_push(2, 8'h50, 1'b1);
    exp_push(8'h40, 3'd1, 1'b1);
    exp_push(8'h50, 3'd2, 1'b0);
    exp_push(8'h41, 3'd1, 1'b0);
    n = 0;
    while (!to_seen && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    mute = 1'b0;
    check_eq("to_seen", to_seen, 1);
    wait_drain(400);
    to_allowed = 1'b0;

    // Reset in the middle of a locked packet's frame.
    start_test(1'b0);
    src_push(1, 8'h60, 1'b0); src_push(1, 8'h61, 1'b0); src_push(1, 8'h62, 1'b1);
    exp_push(8'h60, 3'd1, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check_eq("pre_rst_locked", bus.locked, 1);
    reset = 1'b1;
    exp_q.delete();
    src_push(0, 8'h30, 1'b1);
    exp_push(8'h30, 3'd0, 1'b0);
    exp_push(8'h61, 3'd1, 1'b1);
    exp_push(8'h62, 3'd1, 1'b0);
    @(posedge clk); #2;
    check_eq("mid_rst_tx_wr", bus.tx_wr, 0);
    check_eq("mid_rst_ready", bus.req_ready, 0);
    check_eq("mid_rst_locked", bus.locked, 0);
    check_eq("mid_rst_grant", bus.grant_id, 0);
    reset = 1'b0;
    wait_drain(400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
